// File: rtl/line_window_gen.sv
// line_window_gen: KSIZE x KSIZE sliding window over a raster pixel stream; define WIN_CNT_EN to add the win_cnt output
module line_window_gen #(
  parameter int PIX_W = 8,
  parameter int KSIZE = 5,
  parameter int IMG_W = 516,
  parameter int IMG_H = 516
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               in_pix,
  input  logic                           in_valid,
  input  logic                           in_sof,
  output logic                           in_ready,
  output logic [KSIZE*KSIZE*PIX_W-1:0]   out_win,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_done
`ifdef WIN_CNT_EN
  ,
  output logic [19:0]                    win_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_K = CW'(KSIZE - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_K = RW'(KSIZE - 1);
  logic [CW-1:0] col, cur_c;
  logic [RW-1:0] row, cur_r;
  logic [PIX_W-1:0] lb [KSIZE-1][IMG_W];
  logic [PIX_W-1:0] win [KSIZE][KSIZE];
  logic [PIX_W-1:0] col_vec [KSIZE];
  logic acc, at_win, at_last;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign cur_c = in_sof ? '0 : col;
  assign cur_r = in_sof ? '0 : row;
  assign at_win = cur_r >= R_K && cur_c >= C_K;
  assign at_last = cur_r == R_LAST && cur_c == C_LAST;
  // vertical column at the current position, oldest line first, newest pixel last
  always_comb begin
    for (int i = 0; i < KSIZE-1; i++) col_vec[i] = lb[i][cur_c];
    col_vec[KSIZE-1] = in_pix;
  end
  // line buffers: move this column up one line and store the new pixel as the newest line
  always_ff @(posedge clk)
    if (acc) begin
      for (int i = 0; i < KSIZE-2; i++) lb[i][cur_c] <= lb[i+1][cur_c];
      lb[KSIZE-2][cur_c] <= in_pix;
    end
  // position counters and window shift register, both advancing only on accept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++) win[i][j] <= '0;
    end else if (acc) begin
      col <= cur_c == C_LAST ? '0 : cur_c + 1'b1;
      row <= cur_c != C_LAST ? cur_r : (cur_r == R_LAST ? '0 : cur_r + 1'b1);
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE-1; j++) win[i][j] <= win[i][j+1];
        win[i][KSIZE-1] <= col_vec[i];
      end
    end
  // output handshake and last-window pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid <= (acc && at_win) || (out_valid && !out_ready);
      frame_done <= acc && at_last;
    end
  for (genvar r = 0; r < KSIZE; r++) begin : g_r
    for (genvar c = 0; c < KSIZE; c++) begin : g_c
      assign out_win[(r*KSIZE+c)*PIX_W +: PIX_W] = win[r][c];
    end
  end
`ifdef WIN_CNT_EN
  // delivered windows since the most recent start of frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) win_cnt <= '0;
    else if (acc && in_sof) win_cnt <= '0;
    else if (out_valid && out_ready) win_cnt <= win_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: randomized checks of line_window_gen against an image-array reference model
module tb_line_window_gen;
  localparam int PW = 8;
  localparam int K = 3;
  localparam int W = 6;
  localparam int H = 5;
  localparam int WW = K*K*PW;
  localparam int NWIN = (W-K+1)*(H-K+1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PW-1:0] in_pix = '0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, frame_done;
  logic [WW-1:0] out_win;
`ifdef WIN_CNT_EN
  logic [19:0] win_cnt;
`endif
  int tests = 0;
  int fails = 0;
  logic [PW-1:0] img [H][W];
  int pidx = 0;
  bit exp_valid = 1'b0;
  bit exp_done = 1'b0;
  logic [WW-1:0] exp_win = '0;
  int n_xfer = 0;
  int n_done = 0;

  line_window_gen #(.PIX_W(PW), .KSIZE(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst(rst),
    .in_pix(in_pix),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_ready(in_ready),
    .out_win(out_win),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done)
`ifdef WIN_CNT_EN
    ,
    .win_cnt(win_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // window whose pixel values are their raster indices, top-left at (r0,c0)
  function automatic logic [WW-1:0] raster_win(input int r0, input int c0);
    logic [WW-1:0] w;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) w[(i*K+j)*PW +: PW] = PW'((r0+i)*W + c0 + j);
    return w;
  endfunction

  // one clock: drive inputs, advance the model, then check the registered outputs
  task automatic step(input bit v, input logic [PW-1:0] pix, input bit sof, input bit ordy, output bit acc);
    int r, c;
    bit rdy;
    in_valid = v;
    in_pix = pix;
    in_sof = sof;
    out_ready = ordy;
    #1;
    rdy = !exp_valid || ordy;
    tests++;
    if (in_ready !== rdy) begin
      fails++;
      $display("FAIL in_ready: got %b expected %b", in_ready, rdy);
    end
    if (out_valid === 1'b1 && ordy) n_xfer++;
    acc = v && rdy;
    if (ordy) exp_valid = 1'b0;
    exp_done = 1'b0;
    if (acc) begin
      if (sof) pidx = 0;
      r = pidx / W;
      c = pidx % W;
      img[r][c] = pix;
      if (r >= K-1 && c >= K-1) begin
        exp_valid = 1'b1;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) exp_win[(i*K+j)*PW +: PW] = img[r-K+1+i][c-K+1+j];
      end
      exp_done = r == H-1 && c == W-1;
      pidx = (pidx + 1) % (W*H);
    end
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) n_done++;
    tests++;
    if (out_valid !== exp_valid) begin
      fails++;
      $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid);
    end
    tests++;
    if (frame_done !== exp_done) begin
      fails++;
      $display("FAIL frame_done: got %b expected %b", frame_done, exp_done);
    end
    if (exp_valid) begin
      tests++;
      if (out_win !== exp_win) begin
        fails++;
        $display("FAIL out_win: got %h expected %h", out_win, exp_win);
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_win !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b done=%b win=%h expected 0 0 0", out_valid, frame_done, out_win);
    end
`ifdef WIN_CNT_EN
    tests++;
    if (win_cnt !== 20'd0) begin
      fails++;
      $display("FAIL reset_win_cnt: got %0d expected 0", win_cnt);
    end
`endif
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    exp_valid = 1'b0;
    exp_done = 1'b0;
    pidx = 0;
  endtask

  task automatic feed(input int n, input bit sof0, input bit rv, input bit rr);
    bit a;
    int i = 0;
    int g = 0;
    while (i < n && g < 4000) begin
      step(rv ? ($urandom_range(0, 3) != 0) : 1'b1, PW'($urandom), sof0 && i == 0,
           rr ? ($urandom_range(0, 2) != 0) : 1'b1, a);
      if (a) i++;
      g++;
    end
    tests++;
    if (i < n) begin
      fails++;
      $display("FAIL feed_budget: accepted %0d pixels, required %0d", i, n);
    end
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, a);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic check_counts(input string name, input int wins, input int dones);
    tests++;
    if (n_xfer !== wins || n_done !== dones) begin
      fails++;
      $display("FAIL %s_counts: got windows=%0d done=%0d expected %0d %0d", name, n_xfer, n_done, wins, dones);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_raster();
    bit a;
    n_xfer = 0;
    n_done = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, PW'(i), i == 0, 1'b1, a);
      if (i == 13) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL raster_early: out_valid got %b expected 0", out_valid);
        end
      end
      if (i == 14) begin
        tests++;
        if (out_valid !== 1'b1 || out_win !== raster_win(0, 0)) begin
          fails++;
          $display("FAIL raster_first: got %b %h expected 1 %h", out_valid, out_win, raster_win(0, 0));
        end
      end
    end
    drain();
    check_counts("raster", NWIN, 1);
`ifdef WIN_CNT_EN
    tests++;
    if (win_cnt !== 20'(NWIN)) begin
      fails++;
      $display("FAIL raster_win_cnt: got %0d expected %0d", win_cnt, NWIN);
    end
`endif
  endtask

  task automatic test_stall();
    bit a;
    n_xfer = 0;
    n_done = 0;
    for (int i = 0; i < 15; i++) step(1'b1, PW'(i), i == 0, 1'b1, a);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, PW'(15), 1'b0, 1'b0, a);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_win !== raster_win(0, 0)) begin
        fails++;
        $display("FAIL stall_hold: got rdy=%b valid=%b win=%h expected 0 1 %h", in_ready, out_valid, out_win, raster_win(0, 0));
      end
    end
    for (int i = 15; i < W*H; i++) step(1'b1, PW'(i), 1'b0, 1'b1, a);
    drain();
    check_counts("stall", NWIN, 1);
  endtask

  task automatic test_sof_abort();
    bit a;
    n_xfer = 0;
    n_done = 0;
    for (int i = 0; i < 20; i++) step(1'b1, PW'($urandom), i == 0, 1'b1, a);
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, PW'($urandom), i == 0, 1'b1, a);
      if (i == 13 || i == 14) begin
        tests++;
        if (out_valid !== (i == 14)) begin
          fails++;
          $display("FAIL sof_first_window: pixel %0d out_valid got %b expected %b", i, out_valid, i == 14);
        end
      end
    end
    drain();
    check_counts("sof_abort", NWIN + 4, 1);
  endtask

  task automatic test_back_to_back();
    n_xfer = 0;
    n_done = 0;
    feed(W*H, 1'b1, 1'b0, 1'b0);
    feed(W*H, 1'b0, 1'b0, 1'b0);
    feed(W*H, 1'b1, 1'b0, 1'b0);
    drain();
    check_counts("back_to_back", 3*NWIN, 3);
  endtask

  task automatic test_random();
    n_xfer = 0;
    n_done = 0;
    feed(W*H, 1'b1, 1'b1, 1'b1);
    feed(W*H, 1'b1, 1'b1, 1'b1);
    drain();
    check_counts("random", 2*NWIN, 2);
  endtask

  task automatic test_reset_mid();
    bit a;
    for (int i = 0; i < 18; i++) step(1'b1, PW'($urandom), i == 0, 1'b1, a);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pending: out_valid got %b expected 1", out_valid);
    end
    do_reset();
    n_xfer = 0;
    n_done = 0;
    feed(W*H, 1'b0, 1'b0, 1'b1);
    drain();
    check_counts("reset_mid", NWIN, 1);
`ifdef WIN_CNT_EN
    tests++;
    if (win_cnt !== 20'(NWIN)) begin
      fails++;
      $display("FAIL reset_mid_win_cnt: got %0d expected %0d", win_cnt, NWIN);
    end
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raster();
    test_stall();
    test_sof_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 PIX_W, default 8: pixel width in bits.
REQ-003 KSIZE, default 5: window edge length (odd, 3..13).
REQ-004 IMG_W, default 516: padded line length in pixels.
REQ-005 IMG_H, default 516: padded frame height in lines.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  async active-low reset.
REQ-008 in_pix  in  PIX_W  raster-order pixel.
REQ-009 in_valid  in  1  in_pix valid.
REQ-010 in_sof  in  1  marks first pixel of a frame; qualified by in_valid.
REQ-011 in_ready  out  1  block accepts in_pix this cycle.
REQ-012 out_win  out  KSIZE*KSIZE*PIX_W  window; element (r,c) at bits [(r*KSIZE+c)*PIX_W +: PIX_W], r=0 is the oldest line, c=0 the leftmost column.
REQ-013 out_valid  out  1  out_win valid.
REQ-014 out_ready  in  1  downstream accepts out_win.
REQ-015 frame_done  out  1  one-cycle pulse on the last window of a frame.

Function
REQ-016 A pixel SHALL be accepted when in_valid and in_ready are both 1; in_ready = !out_valid || out_ready.
REQ-017 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL track the position of the accepted pixel; col wraps to 0 and row increments after IMG_W-1; both wrap to 0 after (IMG_H-1, IMG_W-1).
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as position (0,0), with the counters restarting from it.
REQ-019 KSIZE-1 line buffers of IMG_W entries each SHALL hold previous lines, alongside a KSIZE x KSIZE shift-register window updated only on accept.
REQ-020 Accepting pixel (R,C) with R>=KSIZE-1 and C>=KSIZE-1 SHALL produce, on the next cycle, out_valid=1 with element (r,c) = pixel(R-KSIZE+1+r, C-KSIZE+1+c); latency is exactly 1 cycle.
REQ-021 Positions with R<KSIZE-1 or C<KSIZE-1 SHALL produce no output; each frame yields (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1) windows (262144 at defaults).
REQ-022 out_valid and out_win SHALL hold stable while out_valid=1 and out_ready=0; out_valid clears after the transfer unless a new window is produced in the same cycle.
REQ-023 frame_done SHALL be 1 for exactly the cycle in which out_valid first presents the window for (IMG_H-1, IMG_W-1).
REQ-024 When out_valid=1 and out_ready=1, a simultaneous accept SHALL be allowed (full throughput, one window per cycle).
REQ-025 When in_sof arrives mid-frame, the partial frame SHALL be abandoned without raising frame_done; any pending out_valid window is still delivered.

Reset
REQ-026 On rst=0: out_valid=0, frame_done=0, out_win=0, col=0, row=0, win_cnt=0; in_ready=1 after release.
REQ-027 Line buffer contents are not cleared and SHALL not affect output, because rows 0..KSIZE-2 produce no window.
REQ-028 A reset mid-frame SHALL discard any pending window, and the next accepted pixel is position (0,0).

Configuration
REQ-029 Macro WIN_CNT_EN defined: an extra output win_cnt (out, 20 bits) counts completed out transfers in the current frame, cleared on in_sof accept and on reset.
REQ-030 WIN_CNT_EN undefined: no win_cnt port or counter logic; all other behaviour is identical.

Verification
REQ-031 KSIZE=3, IMG_W=6, IMG_H=5, in_pix=raster index, out_ready=1 -> 12 windows; the first has out_win elements {0,1,2,6,7,8,12,13,14}, one cycle after accepting pixel 14.
REQ-032 Same config, out_ready held 0 for 4 cycles at the first window -> in_ready=0 and out_win stable for those 4 cycles, with no pixel lost; the sequence matches REQ-031.
REQ-033 Defaults, full frame of 266256 pixels with continuous valid and ready -> exactly 262144 windows, frame_done pulses once, and win_cnt=262144 when WIN_CNT_EN is defined.
REQ-034 KSIZE=3, IMG_W=6, in_sof re-asserted at pixel 20 of frame 1 -> no frame_done for frame 1, and the next window appears after pixel 14 of the new frame.
REQ-035 rst pulsed low for 1 cycle at pixel 17 while out_valid=1 -> out_valid=0 immediately, and outputs after reset match a fresh frame.
REQ-036 Two back-to-back frames with no idle cycle -> the second frame's windows contain no pixels from the first frame.
